// File: rtl/cpu_nios_debug_pkg.sv
// rtl/cpu_nios_debug_pkg.sv - shared constants for the Nios debug OCI RAM controller
package cpu_nios_debug_pkg;

  localparam int OCI_DATA_W   = 32;
  localparam int JDO_W        = 38;
  localparam int JDO_RD_BIT   = 35;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_ADDR_LSB = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_J_WR  = 3'd1;
  localparam logic [2:0] ST_J_RD  = 3'd2;
  localparam logic [2:0] ST_J_CAP = 3'd3;
  localparam logic [2:0] ST_C_WR  = 3'd4;
  localparam logic [2:0] ST_C_RD  = 3'd5;
  localparam logic [2:0] ST_C_CAP = 3'd6;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_JTAG = 1'b1
  } grant_e;

endpackage

// File: rtl/cpu_nios_debug_ocimem_arbiter.sv
// rtl/cpu_nios_debug_ocimem_arbiter.sv - round-robin OCI RAM sharing between JTAG debug slave and CPU
import cpu_nios_debug_pkg::*;

module cpu_nios_debug_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [JDO_W-1:0]      jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic                  debugack,
  input  logic [ADDR_W-1:0]     avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [OCI_DATA_W-1:0] avs_writedata,
  input  logic [3:0]            avs_byteenable,
  output logic [OCI_DATA_W-1:0] avs_readdata,
  output logic                  avs_waitrequest,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_wr,
  output logic [3:0]            ram_be,
  output logic [OCI_DATA_W-1:0] ram_wdata,
  input  logic [OCI_DATA_W-1:0] ram_rdata,
  output logic [OCI_DATA_W-1:0] MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error
);

  logic [2:0]            state_q, state_d;
  grant_e                last_q, last_d;
  logic [ADDR_W-1:0]     mona_q, mona_d;
  logic [OCI_DATA_W-1:0] mondreg_q, mondreg_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  pend_q, pend_d;
  logic                  pend_wr_q, pend_wr_d;
  logic [ADDR_W-1:0]     pend_addr_q, pend_addr_d;
  logic [OCI_DATA_W-1:0] pend_data_q, pend_data_d;
  logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
  logic                  ram_wr_q, ram_wr_d;
  logic [3:0]            ram_be_q, ram_be_d;
  logic [OCI_DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [OCI_DATA_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0]     jdo_addr;
  logic [OCI_DATA_W-1:0] jdo_data;
  logic                  jdo_rd;
  logic                  any_strobe;
  logic                  accept;
  logic                  jtag_done;
  logic                  cpu_req;
  logic                  grant_j;
  logic                  unused_jdo;

  assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_data   = jdo[JDO_DATA_LSB +: OCI_DATA_W];
  assign jdo_rd     = jdo[JDO_RD_BIT];
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[1:0]};

  assign any_strobe = take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a;
  assign accept     = debugack & ~pend_q;
  assign jtag_done  = (state_q == ST_J_WR) | (state_q == ST_J_CAP);
  assign cpu_req    = avs_read | avs_write;
  // JTAG wins a tie only when the CPU had the previous grant.
  assign grant_j    = pend_q & (~cpu_req | (last_q == GNT_CPU));

  always_comb begin
    mona_d      = mona_q;
    mondreg_d   = mondreg_q;
    ready_d     = ready_q;
    err_d       = err_q;
    pend_d      = pend_q;
    pend_wr_d   = pend_wr_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;

    if (jtag_done) begin
      pend_d  = 1'b0;
      ready_d = 1'b1;
      mona_d  = mona_q + ADDR_W'(1);
    end
    if (state_q == ST_J_CAP) begin
      mondreg_d = ram_rdata;
    end

    // A JTAG state implies pend_q, so an accepted strobe never collides with completion.
    if (any_strobe) begin
      if (!accept) begin
        err_d = 1'b1;
      end else if (take_action_ocimem_b) begin
        pend_d      = 1'b1;
        ready_d     = 1'b0;
        pend_wr_d   = 1'b1;
        pend_addr_d = mona_q;
        pend_data_d = jdo_data;
      end else if (take_action_ocimem_a) begin
        err_d  = 1'b0;
        mona_d = jdo_addr;
        if (jdo_rd) begin
          pend_d      = 1'b1;
          ready_d     = 1'b0;
          pend_wr_d   = 1'b0;
          pend_addr_d = jdo_addr;
        end
      end else begin
        pend_d      = 1'b1;
        ready_d     = 1'b0;
        pend_wr_d   = 1'b0;
        pend_addr_d = mona_q;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = 1'b0;
    ram_be_d    = 4'h0;
    ram_wdata_d = ram_wdata_q;
    rdata_d     = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_j) begin
          last_d     = GNT_JTAG;
          ram_addr_d = pend_addr_q;
          if (pend_wr_q) begin
            state_d     = ST_J_WR;
            ram_wr_d    = 1'b1;
            ram_be_d    = 4'hF;
            ram_wdata_d = pend_data_q;
          end else begin
            state_d = ST_J_RD;
          end
        end else if (cpu_req) begin
          last_d     = GNT_CPU;
          ram_addr_d = avs_address;
          if (avs_write) begin
            state_d     = ST_C_WR;
            ram_wr_d    = 1'b1;
            ram_be_d    = avs_byteenable;
            ram_wdata_d = avs_writedata;
          end else begin
            state_d = ST_C_RD;
          end
        end
      end
      ST_J_RD:  state_d = ST_J_CAP;
      ST_C_RD:  state_d = ST_C_CAP;
      ST_C_CAP: begin
        rdata_d = ram_rdata;
        state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      last_q      <= GNT_CPU;
      mona_q      <= '0;
      mondreg_q   <= '0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_be_q    <= 4'h0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mona_q      <= mona_d;
      mondreg_q   <= mondreg_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      pend_wr_q   <= pend_wr_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_be_q    <= ram_be_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign avs_waitrequest = cpu_req & ~((state_q == ST_C_WR) | (state_q == ST_C_CAP));
  assign avs_readdata    = (state_q == ST_C_CAP) ? ram_rdata : rdata_q;
  assign ram_addr        = ram_addr_q;
  assign ram_wr          = ram_wr_q;
  assign ram_be          = ram_be_q;
  assign ram_wdata       = ram_wdata_q;
  assign MonDReg         = mondreg_q;
  assign monitor_ready   = ready_q;
  assign monitor_error   = err_q;

endmodule
